// File: rtl/lever_frame_decoder.sv
// +----------------------------------------------------------------------------+
// | lever_frame_decoder - checksum-protected N-channel lever frame decoder      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lever_frame_decoder #(
    parameter int          N_CH         = 2,
    parameter int          DATA_W       = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          BYTE_TIMEOUT = 50000,
    parameter int          LINK_TIMEOUT = 5000000,
    parameter bit          ZERO_ON_LOSS = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_error,
    input  logic                     clear_stats,
    output logic [N_CH*DATA_W-1:0]   channels,
    output logic                     frame_valid,
    output logic                     link_ok,
    output logic [7:0]               chk_err_cnt,
    output logic [7:0]               abort_cnt,
    output logic [1:0]               db_estado
);

    localparam int BPC = DATA_W / 8;
    localparam int L   = N_CH * BPC;
    localparam int CW  = $clog2(L + 1);
    localparam int TW  = $clog2(BYTE_TIMEOUT + 1);
    localparam int WW  = $clog2(LINK_TIMEOUT + 1);

    localparam logic [1:0]    S_HUNT    = 2'd0;
    localparam logic [1:0]    S_PAYLOAD = 2'd1;
    localparam logic [1:0]    S_CHECK   = 2'd2;

    localparam logic [CW-1:0] LAST_IDX  = CW'(L - 1);
    localparam logic [TW-1:0] BYTE_TMO  = TW'(BYTE_TIMEOUT);
    localparam logic [WW-1:0] LINK_TMO  = WW'(LINK_TIMEOUT);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [CW-1:0]         byte_cnt;
    logic [7:0]            xor_acc;
    logic [L*8-1:0]        shadow;
    logic [TW-1:0]         byte_timer;
    logic [WW-1:0]         wd_cnt;

    logic                  byte_ok;
    logic                  in_frame;
    logic                  timeout;
    logic                  abort_ev;
    logic                  payload_wr;
    logic                  commit;
    logic                  chk_fail;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_HUNT;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_HUNT:    if (byte_ok && rx_data == SYNC_BYTE) state_nxt = S_PAYLOAD;
            S_PAYLOAD: begin
                if (abort_ev)                              state_nxt = S_HUNT;
                else if (byte_ok && byte_cnt == LAST_IDX)  state_nxt = S_CHECK;
            end
            S_CHECK:   if (abort_ev || byte_ok)            state_nxt = S_HUNT;
            default:                                       state_nxt = S_HUNT;
        endcase
    end

    // Event decode; a byte arriving together with rx_error is dropped
    always_comb begin
        byte_ok    = rx_valid && !rx_error;
        in_frame   = (state == S_PAYLOAD) || (state == S_CHECK);
        timeout    = in_frame && !rx_valid && (byte_timer + 1'b1 == BYTE_TMO);
        abort_ev   = in_frame && (rx_error || timeout);
        payload_wr = (state == S_PAYLOAD) && byte_ok;
        commit     = (state == S_CHECK) && byte_ok && (rx_data == xor_acc);
        chk_fail   = (state == S_CHECK) && byte_ok && (rx_data != xor_acc);
        db_estado  = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            xor_acc    <= '0;
            byte_timer <= '0;
            shadow     <= '0;
        end else begin
            if (state == S_HUNT) begin
                byte_cnt <= '0;
                xor_acc  <= '0;
            end else if (payload_wr) begin
                byte_cnt <= byte_cnt + 1'b1;
                xor_acc  <= xor_acc ^ rx_data;
            end

            if (!in_frame || rx_valid || timeout) byte_timer <= '0;
            else                                  byte_timer <= byte_timer + 1'b1;

            // Stream order is channel 0 first, MSB byte first
            for (int i = 0; i < L; i++) begin
                if (payload_wr && byte_cnt == CW'(i))
                    shadow[(i / BPC) * DATA_W + (BPC - 1 - (i % BPC)) * 8 +: 8] <= rx_data;
            end
        end
    end

    // Commit and link watchdog; a commit overrides a coincident expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            channels    <= '0;
            frame_valid <= 1'b0;
            link_ok     <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            frame_valid <= commit;
            if (commit) begin
                channels <= shadow;
                link_ok  <= 1'b1;
                wd_cnt   <= '0;
            end else if (link_ok) begin
                if (wd_cnt + 1'b1 == LINK_TMO) begin
                    link_ok <= 1'b0;
                    wd_cnt  <= '0;
                    if (ZERO_ON_LOSS) channels <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_cnt <= '0;
            abort_cnt   <= '0;
        end else if (clear_stats) begin
            chk_err_cnt <= '0;
            abort_cnt   <= '0;
        end else begin
            if (chk_fail && chk_err_cnt != 8'hFF) chk_err_cnt <= chk_err_cnt + 1'b1;
            if (abort_ev && abort_cnt   != 8'hFF) abort_cnt   <= abort_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire
